nios_led2_cpu_cpu_ocimem_arbiter: RTL and testbench

Shares the CPU's single-port on-chip debug RAM (OCI memory) between two requesters: the JTAG debug slave's system-clock-side command pulses, and the CPU's Avalon debug-slave port.
- JTAG commands (take_action_ocimem_a/b, take_no_action_ocimem_a with jdo) are latched into a one-deep pending slot.
- CPU accesses are stalled with waitrequest until granted.
- Grants alternate when both sides contend.
- JTAG read data is returned in MonDReg.

---
 rtl/nios_led2_cpu_cpu_ocimem_arbiter_if.sv | 41 ++++
 rtl/nios_led2_cpu_cpu_ocimem_arbiter.sv | 117 +++++++++++
 tb/tb_nios_led2_cpu_cpu_ocimem_arbiter.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/nios_led2_cpu_cpu_ocimem_arbiter_if.sv
// nios_led2_cpu_cpu_ocimem_arbiter_if: JTAG command, Avalon debug-slave and OCI RAM signals of the arbiter
interface nios_led2_cpu_cpu_ocimem_arbiter_if #(
    parameter int ADDR_W = 8
);
    logic [37:0]       jdo;
    logic              take_action_ocimem_a;
    logic              take_action_ocimem_b;
    logic              take_no_action_ocimem_a;
    logic [31:0]       MonDReg;
    logic              jtag_busy;
    logic              jtag_overrun;
    logic [ADDR_W-1:0] cpu_address;
    logic              cpu_read;
    logic              cpu_write;
    logic [31:0]       cpu_writedata;
    logic [3:0]        cpu_byteenable;
    logic              cpu_debugaccess;
    logic [31:0]       cpu_readdata;
    logic              cpu_waitrequest;
    logic [ADDR_W-1:0] ram_address;
    logic              ram_wren;
    logic [3:0]        ram_byteenable;
    logic [31:0]       ram_wrdata;
    logic [31:0]       ram_rddata;

    modport master (
        output jdo, take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a,
        output cpu_address, cpu_read, cpu_write, cpu_writedata, cpu_byteenable, cpu_debugaccess,
        output ram_rddata,
        input  MonDReg, jtag_busy, jtag_overrun, cpu_readdata, cpu_waitrequest,
        input  ram_address, ram_wren, ram_byteenable, ram_wrdata
    );

    modport slave (
        input  jdo, take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a,
        input  cpu_address, cpu_read, cpu_write, cpu_writedata, cpu_byteenable, cpu_debugaccess,
        input  ram_rddata,
        output MonDReg, jtag_busy, jtag_overrun, cpu_readdata, cpu_waitrequest,
        output ram_address, ram_wren, ram_byteenable, ram_wrdata
    );
endinterface

// File: rtl/nios_led2_cpu_cpu_ocimem_arbiter.sv
// nios_led2_cpu_cpu_ocimem_arbiter: shares the single-port OCI RAM between JTAG commands and the CPU debug slave
module nios_led2_cpu_cpu_ocimem_arbiter #(
    parameter int ADDR_W = 8
) (
    input logic                               clk,
    input logic                               reset_n,
    nios_led2_cpu_cpu_ocimem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CPU_RD_WAIT, CPU_ACK, JTAG_RD_WAIT} state_t;

    state_t            state_q, state_d;
    logic              last_jtag_q, last_jtag_d;
    logic [ADDR_W-1:0] jtag_addr_q, jtag_addr_d;
    logic              pend_q, pend_d;
    logic              pend_wr_q, pend_wr_d;
    logic [31:0]       pend_data_q, pend_data_d;
    logic [31:0]       mon_q, mon_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              overrun_q, overrun_d;
    logic              cpu_req, grant_jtag, jtag_done;
    logic              sel_a, sel_na, sel_b, multi, new_req, blocked, accept;

    // Requests are masked while reset is held so no RAM write can leak out combinationally.
    assign cpu_req    = reset_n & (bus.cpu_read | bus.cpu_write);
    assign grant_jtag = (state_q == IDLE) & pend_q & (~cpu_req | ~last_jtag_q);
    assign jtag_done  = (grant_jtag & pend_wr_q) | (state_q == JTAG_RD_WAIT);
    assign sel_a      = bus.take_action_ocimem_a;
    assign sel_na     = bus.take_no_action_ocimem_a & ~sel_a;
    assign sel_b      = bus.take_action_ocimem_b & ~sel_a & ~bus.take_no_action_ocimem_a;
    assign multi      = (bus.take_action_ocimem_a & bus.take_no_action_ocimem_a)
                      | (bus.take_action_ocimem_a & bus.take_action_ocimem_b)
                      | (bus.take_no_action_ocimem_a & bus.take_action_ocimem_b);
    assign new_req    = (sel_a & bus.jdo[34]) | sel_na | sel_b;
    assign blocked    = pend_q & ~jtag_done;
    assign accept     = new_req & ~blocked;

    // JTAG command capture into the one-deep pending slot; address load beats post-increment
    always_comb begin
        jtag_addr_d = sel_a ? bus.jdo[17 +: ADDR_W] : jtag_done ? jtag_addr_q + ADDR_W'(1) : jtag_addr_q;
        pend_d      = accept | (pend_q & ~jtag_done);
        pend_wr_d   = accept ? sel_b : pend_wr_q;
        pend_data_d = accept ? bus.jdo[34:3] : pend_data_q;
        overrun_d   = multi | (new_req & blocked) | (overrun_q & ~sel_a);
    end

    // Arbitration FSM next state and combinational RAM port
    always_comb begin
        state_d            = state_q;
        last_jtag_d        = last_jtag_q;
        mon_d              = mon_q;
        rdata_d            = rdata_q;
        bus.ram_address    = '0;
        bus.ram_wren       = 1'b0;
        bus.ram_byteenable = 4'h0;
        bus.ram_wrdata     = 32'h0;
        case (state_q)
            IDLE: begin
                if (grant_jtag) begin
                    bus.ram_address    = jtag_addr_q;
                    bus.ram_wren       = pend_wr_q;
                    bus.ram_byteenable = pend_wr_q ? 4'hF : 4'h0;
                    bus.ram_wrdata     = pend_wr_q ? pend_data_q : 32'h0;
                    last_jtag_d        = 1'b1;
                    state_d            = pend_wr_q ? IDLE : JTAG_RD_WAIT;
                end else if (cpu_req) begin
                    bus.ram_address    = bus.cpu_address;
                    bus.ram_wren       = ~bus.cpu_read & bus.cpu_debugaccess;
                    bus.ram_byteenable = bus.cpu_read ? 4'h0 : bus.cpu_byteenable;
                    bus.ram_wrdata     = bus.cpu_read ? 32'h0 : bus.cpu_writedata;
                    last_jtag_d        = 1'b0;
                    state_d            = bus.cpu_read ? CPU_RD_WAIT : CPU_ACK;
                end
            end
            CPU_RD_WAIT: begin
                rdata_d = bus.ram_rddata;
                state_d = CPU_ACK;
            end
            CPU_ACK: state_d = IDLE;
            JTAG_RD_WAIT: begin
                mon_d   = bus.ram_rddata;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            last_jtag_q <= 1'b0;
            jtag_addr_q <= '0;
            pend_q      <= 1'b0;
            pend_wr_q   <= 1'b0;
            pend_data_q <= 32'h0;
            mon_q       <= 32'h0;
            rdata_q     <= 32'h0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_jtag_q <= last_jtag_d;
            jtag_addr_q <= jtag_addr_d;
            pend_q      <= pend_d;
            pend_wr_q   <= pend_wr_d;
            pend_data_q <= pend_data_d;
            mon_q       <= mon_d;
            rdata_q     <= rdata_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.MonDReg         = mon_q;
    assign bus.jtag_busy       = pend_q;
    assign bus.jtag_overrun    = overrun_q;
    assign bus.cpu_readdata    = rdata_q;
    assign bus.cpu_waitrequest = state_q != CPU_ACK;
endmodule

// File: tb/tb_nios_led2_cpu_cpu_ocimem_arbiter.sv
// tb_nios_led2_cpu_cpu_ocimem_arbiter: directed checks of JTAG/CPU sharing of the OCI RAM
module tb_nios_led2_cpu_cpu_ocimem_arbiter;
    localparam int AW = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int total = 0;
    int bad = 0;
    int n;
    int acks;
    logic ld;
    logic [7:0] ld_a;
    logic [31:0] ld_d;
    logic [31:0] mem [256];

    always #5 clk = ~clk;

    nios_led2_cpu_cpu_ocimem_arbiter_if #(.ADDR_W(AW)) bus ();

    nios_led2_cpu_cpu_ocimem_arbiter #(.ADDR_W(AW)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    // Single-port RAM with one-cycle read latency and a preload port
    always @(posedge clk) begin
        if (ld) mem[ld_a] <= ld_d;
        if (bus.ram_wren)
            for (int i = 0; i < 4; i++)
                if (bus.ram_byteenable[i]) mem[bus.ram_address][8*i +: 8] <= bus.ram_wrdata[8*i +: 8];
        bus.ram_rddata <= mem[bus.ram_address];
    end

    function automatic logic [37:0] ja(input logic rd, input logic [7:0] a);
        return (38'(rd) << 34) | (38'(a) << 17);
    endfunction

    function automatic logic [37:0] jb(input logic [31:0] d);
        return 38'(d) << 3;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        bus.jdo = '0;
        bus.take_action_ocimem_a = 0;
        bus.take_action_ocimem_b = 0;
        bus.take_no_action_ocimem_a = 0;
        bus.cpu_address = '0;
        bus.cpu_read = 0;
        bus.cpu_write = 0;
        bus.cpu_writedata = '0;
        bus.cpu_byteenable = '0;
        bus.cpu_debugaccess = 0;
        ld = 1; ld_a = 8'h00; ld_d = 32'h13579BDF;
        tick;
        ld_a = 8'h11; ld_d = 32'hCAFEF00D;
        tick;
        ld_a = 8'h20; ld_d = 32'h0;
        tick;
        ld = 0;
        chk("rst_wait", 32'(bus.cpu_waitrequest), 1);
        chk("rst_wren", 32'(bus.ram_wren), 0);
        chk("rst_addr", 32'(bus.ram_address), 0);
        chk("rst_mon", bus.MonDReg, 0);
        chk("rst_busy", 32'(bus.jtag_busy), 0);
        chk("rst_ovr", 32'(bus.jtag_overrun), 0);
        chk("rst_rdata", bus.cpu_readdata, 0);
        reset_n = 1;
        tick;
        // JTAG address load then write
        bus.jdo = ja(0, 8'h10); bus.take_action_ocimem_a = 1;
        tick;
        bus.take_action_ocimem_a = 0; bus.jdo = jb(32'hDEADBEEF); bus.take_action_ocimem_b = 1;
        #1;
        chk("addr_only_busy", 32'(bus.jtag_busy), 0);
        tick;
        bus.take_action_ocimem_b = 0;
        #1;
        chk("jw_wren", 32'(bus.ram_wren), 1);
        chk("jw_addr", 32'(bus.ram_address), 32'h10);
        chk("jw_data", bus.ram_wrdata, 32'hDEADBEEF);
        chk("jw_be", 32'(bus.ram_byteenable), 32'hF);
        chk("jw_busy", 32'(bus.jtag_busy), 1);
        tick;
        chk("jw_busy_after", 32'(bus.jtag_busy), 0);
        chk("jw_wren_after", 32'(bus.ram_wren), 0);
        // JTAG read at post-incremented address
        bus.take_no_action_ocimem_a = 1;
        tick;
        bus.take_no_action_ocimem_a = 0;
        #1;
        chk("jr_inc_addr", 32'(bus.ram_address), 32'h11);
        chk("jr_wren", 32'(bus.ram_wren), 0);
        tick; tick;
        chk("jr_mon11", bus.MonDReg, 32'hCAFEF00D);
        // Address load with read
        bus.jdo = ja(1, 8'h10); bus.take_action_ocimem_a = 1;
        tick;
        bus.take_action_ocimem_a = 0;
        #1;
        chk("ja_rd_addr", 32'(bus.ram_address), 32'h10);
        tick; tick;
        chk("ja_rd_mon", bus.MonDReg, 32'hDEADBEEF);
        bus.take_no_action_ocimem_a = 1;
        tick;
        bus.take_no_action_ocimem_a = 0;
        #1;
        chk("ja_rd_inc", 32'(bus.ram_address), 32'h11);
        tick; tick;
        // CPU write with debugaccess
        bus.cpu_address = 8'h20; bus.cpu_writedata = 32'h12345678; bus.cpu_byteenable = 4'b0011;
        bus.cpu_debugaccess = 1; bus.cpu_write = 1;
        #1;
        chk("cw_wait1", 32'(bus.cpu_waitrequest), 1);
        chk("cw_wren", 32'(bus.ram_wren), 1);
        chk("cw_addr", 32'(bus.ram_address), 32'h20);
        chk("cw_be", 32'(bus.ram_byteenable), 32'h3);
        chk("cw_data", bus.ram_wrdata, 32'h12345678);
        tick;
        chk("cw_ack", 32'(bus.cpu_waitrequest), 0);
        chk("cw_ack_wren", 32'(bus.ram_wren), 0);
        bus.cpu_write = 0;
        tick;
        // CPU write without debugaccess: acknowledged, not performed
        bus.cpu_debugaccess = 0; bus.cpu_writedata = 32'hFFFFFFFF; bus.cpu_byteenable = 4'hF; bus.cpu_write = 1;
        #1;
        chk("cwn_wren", 32'(bus.ram_wren), 0);
        chk("cwn_wait", 32'(bus.cpu_waitrequest), 1);
        tick;
        chk("cwn_ack", 32'(bus.cpu_waitrequest), 0);
        bus.cpu_write = 0;
        tick;
        // CPU read back
        bus.cpu_read = 1;
        #1;
        chk("cr_addr", 32'(bus.ram_address), 32'h20);
        chk("cr_wait1", 32'(bus.cpu_waitrequest), 1);
        tick;
        chk("cr_wait2", 32'(bus.cpu_waitrequest), 1);
        tick;
        chk("cr_ack", 32'(bus.cpu_waitrequest), 0);
        chk("cr_data", bus.cpu_readdata, 32'h00005678);
        bus.cpu_read = 0;
        tick;
        // Contention right after reset: JTAG wins first
        reset_n = 0;
        tick;
        reset_n = 1;
        tick;
        bus.jdo = ja(1, 8'h10); bus.take_action_ocimem_a = 1;
        tick;
        bus.take_action_ocimem_a = 0; bus.cpu_read = 1; bus.cpu_address = 8'h20;
        #1;
        chk("ct_jtag_first", 32'(bus.ram_address), 32'h10);
        n = 0;
        while (bus.cpu_waitrequest && n < 10) begin
            n++;
            tick;
        end
        chk("ct_waits", n, 4);
        chk("ct_cpu_data", bus.cpu_readdata, 32'h00005678);
        chk("ct_mon", bus.MonDReg, 32'hDEADBEEF);
        bus.cpu_read = 0;
        tick;
        // Overrun: second JTAG read while first still pending behind a CPU read
        chk("ov_pre", 32'(bus.jtag_overrun), 0);
        bus.cpu_read = 1; bus.take_no_action_ocimem_a = 1;
        tick;
        bus.take_no_action_ocimem_a = 0;
        #1;
        chk("ov_busy", 32'(bus.jtag_busy), 1);
        tick;
        bus.cpu_read = 0; bus.take_no_action_ocimem_a = 1;
        tick;
        bus.take_no_action_ocimem_a = 0;
        #1;
        chk("ov_set", 32'(bus.jtag_overrun), 1);
        tick; tick;
        chk("ov_done_busy", 32'(bus.jtag_busy), 0);
        chk("ov_sticky", 32'(bus.jtag_overrun), 1);
        bus.jdo = ja(0, 8'h30); bus.take_action_ocimem_a = 1;
        tick;
        bus.take_action_ocimem_a = 0;
        chk("ov_clear", 32'(bus.jtag_overrun), 0);
        // Simultaneous pulses: a wins, b dropped
        bus.take_action_ocimem_a = 1; bus.take_action_ocimem_b = 1;
        tick;
        bus.take_action_ocimem_a = 0; bus.take_action_ocimem_b = 0;
        chk("multi_ovr", 32'(bus.jtag_overrun), 1);
        chk("multi_busy", 32'(bus.jtag_busy), 0);
        // Address wrap
        bus.jdo = ja(0, 8'hFF); bus.take_action_ocimem_a = 1;
        tick;
        bus.take_action_ocimem_a = 0;
        chk("wrap_ovr_clr", 32'(bus.jtag_overrun), 0);
        bus.jdo = jb(32'h0BADF00D); bus.take_action_ocimem_b = 1;
        tick;
        bus.take_action_ocimem_b = 0;
        #1;
        chk("wrap_wren", 32'(bus.ram_wren), 1);
        chk("wrap_waddr", 32'(bus.ram_address), 32'hFF);
        tick;
        bus.take_no_action_ocimem_a = 1;
        tick;
        bus.take_no_action_ocimem_a = 0;
        #1;
        chk("wrap_addr0", 32'(bus.ram_address), 0);
        tick; tick;
        chk("wrap_mon", bus.MonDReg, 32'h13579BDF);
        // Reset during CPU_RD_WAIT
        bus.cpu_address = 8'h20; bus.cpu_read = 1;
        tick;
        chk("rr_wait", 32'(bus.cpu_waitrequest), 1);
        #2 reset_n = 0;
        #1;
        chk("rr_wait_rst", 32'(bus.cpu_waitrequest), 1);
        chk("rr_wren_rst", 32'(bus.ram_wren), 0);
        chk("rr_addr_rst", 32'(bus.ram_address), 0);
        chk("rr_rdata_rst", bus.cpu_readdata, 0);
        chk("rr_mon_rst", bus.MonDReg, 0);
        bus.cpu_read = 0;
        tick;
        reset_n = 1;
        acks = 0;
        for (int k = 0; k < 4; k++) begin
            tick;
            if (!bus.cpu_waitrequest) acks++;
        end
        chk("rr_no_ack", acks, 0);
        chk("rr_rdata_after", bus.cpu_readdata, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
